// File: rtl/sd_drive_arbiter.sv
// Routes the FDC sector request stream to one hps_io virtual-disk channel and tracks per-drive mount state.
// Optional write protection of read-only images is enabled by defining SD_ARB_WP_EN.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for fdc_rd/fdc_wr; validates drive, mount and WP
// S_ISSUE | strobe held on the selected channel until ack or timeout
// S_XFER  | buffer transfer window while the selected ack stays high
// S_DONE  | one-cycle completion pulse, fdc_err qualifies it
module sd_drive_arbiter #(
  parameter int NBDRIV  = 4,
  parameter int LBA_W   = 32,
  parameter int TIMEOUT = 4200000,
  localparam int DW = (NBDRIV > 1) ? $clog2(NBDRIV) : 1,
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                    clk_sys,
  input  logic                    reset_n,
  input  logic [DW-1:0]           fdc_drive,
  input  logic [LBA_W-1:0]        fdc_lba,
  input  logic                    fdc_rd,
  input  logic                    fdc_wr,
  output logic                    fdc_busy,
  output logic                    fdc_xfer,
  output logic                    fdc_done,
  output logic                    fdc_err,
  output logic [NBDRIV*LBA_W-1:0] sd_lba,
  output logic [NBDRIV-1:0]       sd_rd,
  output logic [NBDRIV-1:0]       sd_wr,
  input  logic [NBDRIV-1:0]       sd_ack,
  input  logic [NBDRIV-1:0]       img_mounted,
  input  logic                    img_readonly,
  input  logic [63:0]             img_size,
  output logic [NBDRIV-1:0]       drv_mounted,
  output logic [NBDRIV-1:0]       drv_readonly
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_DONE} state_t;

  state_t        state, state_nx;
  logic [DW-1:0] cur, cur_nx;
  logic          dir, dir_nx;
  logic          err, err_nx;
  logic [TW-1:0] tmr, tmr_nx;

  logic ack_cur, mnt_evt;
  logic req_valid, req_mnt, req_ro, wp_block, tmo_hit, load_lba;

  // Only the selected channel is looked at; drive numbers past NBDRIV select nothing.
  always_comb begin
    ack_cur   = 1'b0;
    mnt_evt   = 1'b0;
    req_valid = 1'b0;
    req_mnt   = 1'b0;
    req_ro    = 1'b0;
    for (int d = 0; d < NBDRIV; d++) begin
      if (cur == DW'(d)) begin
        ack_cur = sd_ack[d];
        mnt_evt = img_mounted[d];
      end
      if (fdc_drive == DW'(d)) begin
        req_valid = 1'b1;
        req_mnt   = drv_mounted[d];
        req_ro    = drv_readonly[d];
      end
    end
  end

`ifdef SD_ARB_WP_EN
  assign wp_block = fdc_wr && !fdc_rd && req_ro;
`else
  assign wp_block = 1'b0;
`endif

  // Fires on the cycle whose increment would make the count reach TIMEOUT.
  assign tmo_hit = (TIMEOUT != 0) && (tmr == TW'(TIMEOUT - 1));

  always_comb begin
    state_nx = state;
    cur_nx   = cur;
    dir_nx   = dir;
    err_nx   = err;
    tmr_nx   = '0;
    case (state)
      S_IDLE: begin
        err_nx = 1'b0;
        if (fdc_rd || fdc_wr) begin
          cur_nx = fdc_drive;
          dir_nx = !fdc_rd;
          if (!req_valid || !req_mnt || wp_block) begin
            err_nx   = 1'b1;
            state_nx = S_DONE;
          end else begin
            state_nx = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        if (mnt_evt) err_nx = 1'b1;
        if (ack_cur) begin
          state_nx = S_XFER;
        end else if (tmo_hit) begin
          err_nx   = 1'b1;
          state_nx = S_DONE;
        end else begin
          tmr_nx = tmr + TW'(1);
        end
      end
      S_XFER: begin
        if (mnt_evt) err_nx = 1'b1;
        if (!ack_cur) state_nx = S_DONE;
      end
      S_DONE: begin
        err_nx   = 1'b0;
        state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  assign load_lba = (state == S_IDLE) && (state_nx == S_ISSUE);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cur      <= '0;
      dir      <= 1'b0;
      err      <= 1'b0;
      tmr      <= '0;
      fdc_busy <= 1'b0;
      fdc_xfer <= 1'b0;
      fdc_done <= 1'b0;
      fdc_err  <= 1'b0;
      sd_rd    <= '0;
      sd_wr    <= '0;
      sd_lba   <= '0;
    end else begin
      state    <= state_nx;
      cur      <= cur_nx;
      dir      <= dir_nx;
      err      <= err_nx;
      tmr      <= tmr_nx;
      fdc_busy <= (state_nx != S_IDLE);
      fdc_xfer <= (state_nx == S_XFER) && ack_cur;
      fdc_done <= (state_nx == S_DONE);
      fdc_err  <= (state_nx == S_DONE) && err_nx;
      for (int d = 0; d < NBDRIV; d++) begin
        sd_rd[d] <= (state_nx == S_ISSUE) && !dir_nx && (cur_nx == DW'(d));
        sd_wr[d] <= (state_nx == S_ISSUE) &&  dir_nx && (cur_nx == DW'(d));
        if (load_lba && (cur_nx == DW'(d))) sd_lba[d*LBA_W +: LBA_W] <= fdc_lba;
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      drv_mounted <= '0;
    end else begin
      for (int d = 0; d < NBDRIV; d++)
        if (img_mounted[d]) drv_mounted[d] <= |img_size;
    end
  end

`ifdef SD_ARB_WP_EN
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      drv_readonly <= '0;
    end else begin
      for (int d = 0; d < NBDRIV; d++)
        if (img_mounted[d]) drv_readonly[d] <= img_readonly;
    end
  end
`else
  // hps_io enforces read-only images itself in this build.
  logic unused_readonly;
  assign unused_readonly = img_readonly;
  assign drv_readonly    = '0;
`endif

endmodule

// File: doc/sd_drive_arbiter.md
# sd_drive_arbiter

Routes the single floppy-controller sector request stream to the per-drive virtual-disk channels of `hps_io`, replacing per-drive replication of one LBA and an OR of all acks. It latches each request with its drive number and issues it on exactly one channel. It tracks per-drive mount and read-only state and reports completion, error and timeout back to the FDC. It sits between the `trs80` FDC sector interface and `hps_io` (`VDNUM=NBDRIV`) in the top level.

## Interface
Parameters:
- `NBDRIV`, 4: number of drive channels, 1..8.
- `LBA_W`, 32: sector address width.
- `TIMEOUT`, 4200000: `clk_sys` cycles allowed in ISSUE before the request fails; 0 disables the timeout.

Ports:
- `clk_sys`  in  1  system clock (42 MHz).
- `reset_n`  in  1  asynchronous, active-low reset.
- `fdc_drive`  in  $clog2(NBDRIV) (min 1)  target drive, sampled with the request.
- `fdc_lba`  in  LBA_W  sector address, sampled with the request.
- `fdc_rd`  in  1  read request; sampled in IDLE only.
- `fdc_wr`  in  1  write request; sampled in IDLE only.
- `fdc_busy`  out  1  high while a request is in progress.
- `fdc_xfer`  out  1  buffer transfer window, equal to `sd_ack[cur]` while in XFER.
- `fdc_done`  out  1  one-cycle completion pulse.
- `fdc_err`  out  1  qualifies `fdc_done`; high when the request failed.
- `sd_lba`  out  NBDRIV*LBA_W  per-channel LBA, packed with drive 0 in the LSBs.
- `sd_rd`  out  NBDRIV  per-channel read strobe.
- `sd_wr`  out  NBDRIV  per-channel write strobe.
- `sd_ack`  in  NBDRIV  per-channel ack from `hps_io`.
- `img_mounted`  in  NBDRIV  one-cycle mount pulse per drive.
- `img_readonly`  in  1  valid together with `img_mounted`.
- `img_size`  in  64  image size in bytes, valid together with `img_mounted`.
- `drv_mounted`  out  NBDRIV  drive has a non-empty image.
- `drv_readonly`  out  NBDRIV  drive image is read-only.

## Operation
States: IDLE, ISSUE, XFER, DONE.
- **IDLE**: when `fdc_rd|fdc_wr`, latch `cur=fdc_drive`, `lba=fdc_lba`, `dir=wr` (`fdc_rd` wins if both are high).
  - If `cur>=NBDRIV`, or the drive is not mounted, or the WP check fails (see Configuration): go to DONE with `err=1`.
  - Otherwise go to ISSUE.
- **ISSUE**: drive `sd_rd[cur]` or `sd_wr[cur]` high. All other channels stay at 0. `sd_lba[cur]=lba`.
  - On the first cycle `sd_ack[cur]`=1: drop the strobe and go to XFER.
  - If the timeout counter reaches TIMEOUT: drop the strobe and go to DONE with `err=1`.
- **XFER**: `fdc_xfer=sd_ack[cur]`. When `sd_ack[cur]`=0 is sampled, go to DONE.
- **DONE**: `fdc_done=1` and `fdc_err=err` for exactly one cycle, then go to IDLE. `err` clears on entry to IDLE.
- `fdc_busy` is 1 in ISSUE, XFER and DONE.
- `sd_lba[d]` holds its last issued value; it is 0 after reset.
- Acks on non-selected channels are ignored.
- **Mount tracking**: on `img_mounted[d]`, set `drv_mounted[d]=|img_size` and `drv_readonly[d]=img_readonly`. Multiple bits may pulse in the same cycle; all of them update.
- **Mount during a request**: `img_mounted[cur]` during ISSUE or XFER sets `err`. The handshake still completes normally.

## Timing
- Reset values: all outputs 0, state IDLE, timeout counter 0.
- Request sampled at cycle 0 → `fdc_busy` and `sd_rd/wr[cur]` high at cycle 1. All outputs are registered.
- Ack rise sampled at cycle n → strobe low at n+1.
- Ack fall sampled at cycle m → `fdc_done` at m+1, `fdc_busy` low at m+2.
- Immediate error: request at cycle 0 → `fdc_done=fdc_err=1` at cycle 1; no strobe is issued.
- A request held high through DONE is re-sampled in IDLE as a new request. The FDC must drop `fdc_rd`/`fdc_wr` on `fdc_done`.
- Timeout counter: width $clog2(TIMEOUT+1). It counts only in ISSUE and clears on every state exit.
- `reset_n` low mid-request: all strobes drop immediately (asynchronously), mount state clears, and no `fdc_done` is issued.

## Configuration
- `SD_ARB_WP_EN` defined:
  - A write to a drive with `drv_readonly[cur]=1` is rejected with `fdc_done`+`fdc_err` at cycle 1.
  - No `sd_wr` is asserted.
- Not defined:
  - No write check; the write is issued and `hps_io` decides.
  - `drv_readonly` is tied to 0.

## Test plan
- Mount drive 2 (size 89600) → `fdc_rd=1`, drive 2, LBA 0x15:
  - `sd_rd=4'b0100` at cycle 1 and `sd_lba[2]=0x15`.
  - Ack high for 512 cycles → `fdc_xfer` high for 512 cycles.
  - `fdc_done=1`, `fdc_err=0` one cycle after the ack falls.
- Read drive 1 with no image mounted → `fdc_done=fdc_err=1` at cycle 1; `sd_rd` stays 0.
- With `SD_ARB_WP_EN`: mount drive 0 read-only, then `fdc_wr` → error at cycle 1, `sd_wr=0`. Without the macro: `sd_wr[0]=1`.
- TIMEOUT=100, read a mounted drive with no ack → strobe drops and `fdc_done=fdc_err=1` at cycle 101.
- `img_mounted[3]` pulse during XFER on drive 3 → transfer completes, then `fdc_err=1`.
- `reset_n` low during ISSUE → `sd_rd` is 0 in the same cycle; all outputs are 0 after release.
